decoder_frame_packer: RTL and testbench

- Sits directly downstream of the Decoder stage and consumes its decoded axi_stream output.
- Buffers decoded words in a small synchronous FIFO and re-emits them as fixed-length frames.
- Marks the final beat of each frame with tlast so DMA / packetising logic further downstream can move whole frames.
- Exposes fill level and completed-frame count for status registers.

---
 rtl/decoder_frame_packer.sv | 123 ++++++++++++
 tb/tb_decoder_frame_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_frame_packer.sv
// Buffers decoded words in a small FIFO and re-emits them as fixed-length frames with tlast; push-to-output latency 1 cycle.
// Backpressure: input ready is registered !full (no pass-through when full); output valid stalls with data/dest/tlast held.
module decoder_frame_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_FRAME  = 256,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int FW = $clog2(FIFO_DEPTH) + 1,
  localparam int LW = $clog2(MAX_FRAME) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LW-1:0]         frame_length,
  input  logic [DATA_WIDTH-1:0] data_in_data,
  input  logic [DEST_WIDTH-1:0] data_in_dest,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out_data,
  output logic [DEST_WIDTH-1:0] data_out_dest,
  output logic                  data_out_valid,
  output logic                  data_out_tlast,
  input  logic                  data_out_ready,
  output logic [FW-1:0]         fill_level,
  output logic [15:0]           frame_count
);

  localparam logic [FW-1:0] DEPTH_F = FW'(FIFO_DEPTH);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_FRAME);

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [DEST_WIDTH-1:0] dest_mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_nxt;
  logic          ready_q;
  logic [LW-1:0] beat_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_in;
  logic [LW-1:0] cur_len;
  logic [15:0]   frame_cnt_q;
  logic          empty;
  logic          push;
  logic          pop;
  logic          last_beat;

  always_comb begin
    len_in = frame_length;
    if (frame_length == '0) begin
      len_in = LW'(1);
    end else if (frame_length > MAX_L) begin
      len_in = MAX_L;
    end
  end

  // On the first beat the live length applies, so L=1 frames flag tlast immediately.
  assign cur_len   = (beat_q == '0) ? len_in : len_q;
  assign last_beat = (beat_q == cur_len - LW'(1));

  assign empty          = (fill_q == '0);
  assign data_out_valid = !empty && enable && !reset;
  assign data_out_tlast = data_out_valid && last_beat;
  assign data_out_data  = data_mem[rd_ptr];
  assign data_out_dest  = dest_mem[rd_ptr];
  assign data_in_ready  = ready_q && !reset;
  assign fill_level     = fill_q;
  assign frame_count    = frame_cnt_q;

  assign push = data_in_valid && data_in_ready;
  assign pop  = data_out_valid && data_out_ready;

  always_comb begin
    fill_nxt = fill_q;
    case ({push, pop})
      2'b10:   fill_nxt = fill_q + FW'(1);
      2'b01:   fill_nxt = fill_q - FW'(1);
      default: fill_nxt = fill_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr] <= data_in_data;
      dest_mem[wr_ptr] <= data_in_dest;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_q      <= '0;
      ready_q     <= 1'b1;
      beat_q      <= '0;
      len_q       <= LW'(1);
      frame_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fill_q  <= fill_nxt;
      ready_q <= (fill_nxt != DEPTH_F);
      if (pop) begin
        if (beat_q == '0) begin
          len_q <= len_in;
        end
        if (last_beat) begin
          beat_q      <= '0;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          beat_q <= beat_q + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_frame_packer.sv
// Directed bench for decoder_frame_packer: per-cycle vector tables plus hand-written stall, length and reset sequences.
module tb_decoder_frame_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [8:0]  frame_length = 9'd4;
  logic [31:0] in_data = '0;
  logic [7:0]  in_dest = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [7:0]  out_dest;
  logic        out_valid;
  logic        out_tlast;
  logic        out_ready = 1'b0;
  logic [4:0]  fill_level;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;

  decoder_frame_packer dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .frame_length   (frame_length),
    .data_in_data   (in_data),
    .data_in_dest   (in_dest),
    .data_in_valid  (in_valid),
    .data_in_ready  (in_ready),
    .data_out_data  (out_data),
    .data_out_dest  (out_dest),
    .data_out_valid (out_valid),
    .data_out_tlast (out_tlast),
    .data_out_ready (out_ready),
    .fill_level     (fill_level),
    .frame_count    (frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        en;
    logic [8:0]  fl;
    logic        ivld;
    logic [31:0] idat;
    logic [7:0]  idst;
    logic        ordy;
    logic        evld;
    logic [31:0] edat;
    logic [7:0]  edst;
    logic        elast;
    logic        erdy;
    logic [4:0]  efill;
    logic [15:0] efc;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [8:0] fl, input logic ivld,
                              input logic [31:0] idat, input logic [7:0] idst, input logic ordy,
                              input logic evld, input logic [31:0] edat, input logic [7:0] edst,
                              input logic elast, input logic erdy, input logic [4:0] efill,
                              input logic [15:0] efc);
    vec_t v;
    v.en = en; v.fl = fl; v.ivld = ivld; v.idat = idat; v.idst = idst; v.ordy = ordy;
    v.evld = evld; v.edat = edat; v.edst = edst; v.elast = elast; v.erdy = erdy;
    v.efill = efill; v.efc = efc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    enable       = v.en;
    frame_length = v.fl;
    in_valid     = v.ivld;
    in_data      = v.idat;
    in_dest      = v.idst;
    out_ready    = v.ordy;
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'(v.evld));
    if (v.evld) begin
      chk({tag, ".data"}, out_data, v.edat);
      chk({tag, ".dest"}, 32'(out_dest), 32'(v.edst));
    end
    chk({tag, ".tlast"}, 32'(out_tlast), 32'(v.elast));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.erdy));
    chk({tag, ".fill"}, 32'(fill_level), 32'(v.efill));
    chk({tag, ".frame_count"}, 32'(frame_count), 32'(v.efc));
    @(posedge clock); #1;
  endtask

  task automatic run_tbl(input vec_t q[$], input string name);
    foreach (q[i]) run_vec(q[i], $sformatf("%s[%0d]", name, i));
    in_valid = 1'b0;
  endtask

  // Reset is held for one cycle with enable high so any stored data would otherwise be visible.
  task automatic do_reset(input string tag);
    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, 32'(out_valid), 0);
    chk({tag, ".rst_ready"}, 32'(in_ready), 0);
    chk({tag, ".rst_tlast"}, 32'(out_tlast), 0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  vec_t t1[$];
  vec_t t3[$];
  vec_t t4[$];
  vec_t t5[$];
  vec_t t6[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int k;
    int pushes;
    logic acc;

    // Test 1: L=4, 8 words streamed, tlast on 0x13 and 0x17.
    t1.push_back(mk(1, 4, 1, 32'h10, 8'h10, 1,  0, 32'h00, 8'h00, 0, 1, 0, 0));
    t1.push_back(mk(1, 4, 1, 32'h11, 8'h11, 1,  1, 32'h10, 8'h10, 0, 1, 1, 0));
    t1.push_back(mk(1, 4, 1, 32'h12, 8'h12, 1,  1, 32'h11, 8'h11, 0, 1, 1, 0));
    t1.push_back(mk(1, 4, 1, 32'h13, 8'h13, 1,  1, 32'h12, 8'h12, 0, 1, 1, 0));
    t1.push_back(mk(1, 4, 1, 32'h14, 8'h14, 1,  1, 32'h13, 8'h13, 1, 1, 1, 0));
    t1.push_back(mk(1, 4, 1, 32'h15, 8'h15, 1,  1, 32'h14, 8'h14, 0, 1, 1, 1));
    t1.push_back(mk(1, 4, 1, 32'h16, 8'h16, 1,  1, 32'h15, 8'h15, 0, 1, 1, 1));
    t1.push_back(mk(1, 4, 1, 32'h17, 8'h17, 1,  1, 32'h16, 8'h16, 0, 1, 1, 1));
    t1.push_back(mk(1, 4, 0, 32'h00, 8'h00, 1,  1, 32'h17, 8'h17, 1, 1, 1, 1));
    t1.push_back(mk(1, 4, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 0, 2));

    // Test 3: L=3 latched, length switched to 5 mid-frame applies to the next frame only.
    t3.push_back(mk(1, 3, 1, 32'hB0, 8'h01, 1,  0, 32'h00, 8'h00, 0, 1, 0, 0));
    t3.push_back(mk(1, 3, 1, 32'hB1, 8'h02, 1,  1, 32'hB0, 8'h01, 0, 1, 1, 0));
    t3.push_back(mk(1, 3, 1, 32'hB2, 8'h03, 1,  1, 32'hB1, 8'h02, 0, 1, 1, 0));
    t3.push_back(mk(1, 5, 1, 32'hB3, 8'h04, 1,  1, 32'hB2, 8'h03, 1, 1, 1, 0));
    t3.push_back(mk(1, 5, 1, 32'hB4, 8'h05, 1,  1, 32'hB3, 8'h04, 0, 1, 1, 1));
    t3.push_back(mk(1, 5, 1, 32'hB5, 8'h06, 1,  1, 32'hB4, 8'h05, 0, 1, 1, 1));
    t3.push_back(mk(1, 5, 1, 32'hB6, 8'h07, 1,  1, 32'hB5, 8'h06, 0, 1, 1, 1));
    t3.push_back(mk(1, 5, 1, 32'hB7, 8'h08, 1,  1, 32'hB6, 8'h07, 0, 1, 1, 1));
    t3.push_back(mk(1, 5, 0, 32'h00, 8'h00, 1,  1, 32'hB7, 8'h08, 1, 1, 1, 1));
    t3.push_back(mk(1, 5, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 0, 2));

    // Test 4a: length 0 behaves as 1, so every beat is last.
    t4.push_back(mk(1, 0, 1, 32'hC0, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 0, 0));
    t4.push_back(mk(1, 0, 1, 32'hC1, 8'h00, 1,  1, 32'hC0, 8'h00, 1, 1, 1, 0));
    t4.push_back(mk(1, 0, 1, 32'hC2, 8'h00, 1,  1, 32'hC1, 8'h00, 1, 1, 1, 1));
    t4.push_back(mk(1, 0, 0, 32'h00, 8'h00, 1,  1, 32'hC2, 8'h00, 1, 1, 1, 2));
    t4.push_back(mk(1, 0, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 0, 3));

    // Test 5: enable dropped after two beats of a 4-beat frame for five cycles.
    t5.push_back(mk(1, 4, 1, 32'hA0, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 0, 0));
    t5.push_back(mk(1, 4, 1, 32'hA1, 8'h00, 1,  1, 32'hA0, 8'h00, 0, 1, 1, 0));
    t5.push_back(mk(1, 4, 1, 32'hA2, 8'h00, 1,  1, 32'hA1, 8'h00, 0, 1, 1, 0));
    t5.push_back(mk(0, 4, 1, 32'hA3, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 1, 0));
    t5.push_back(mk(0, 4, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 2, 0));
    t5.push_back(mk(0, 4, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 2, 0));
    t5.push_back(mk(0, 4, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 2, 0));
    t5.push_back(mk(0, 4, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 2, 0));
    t5.push_back(mk(1, 4, 0, 32'h00, 8'h00, 1,  1, 32'hA2, 8'h00, 0, 1, 2, 0));
    t5.push_back(mk(1, 4, 0, 32'h00, 8'h00, 1,  1, 32'hA3, 8'h00, 1, 1, 1, 0));
    t5.push_back(mk(1, 4, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 0, 1));

    // Test 6 tail: fresh 4-beat frame after a mid-frame reset, dest passed through.
    t6.push_back(mk(1, 4, 1, 32'hE0, 8'hA5, 1,  0, 32'h00, 8'h00, 0, 1, 0, 0));
    t6.push_back(mk(1, 4, 1, 32'hE1, 8'h5A, 1,  1, 32'hE0, 8'hA5, 0, 1, 1, 0));
    t6.push_back(mk(1, 4, 1, 32'hE2, 8'hA5, 1,  1, 32'hE1, 8'h5A, 0, 1, 1, 0));
    t6.push_back(mk(1, 4, 1, 32'hE3, 8'hFF, 1,  1, 32'hE2, 8'hA5, 0, 1, 1, 0));
    t6.push_back(mk(1, 4, 0, 32'h00, 8'h00, 1,  1, 32'hE3, 8'hFF, 1, 1, 1, 0));
    t6.push_back(mk(1, 4, 0, 32'h00, 8'h00, 1,  0, 32'h00, 8'h00, 0, 1, 0, 1));

    do_reset("t1");
    run_tbl(t1, "t1");

    do_reset("t3");
    run_tbl(t3, "t3");

    do_reset("t4");
    run_tbl(t4, "t4");

    // Test 4b: 300 saturates to 256; 257 words give one full frame plus one beat.
    frame_length = 9'd300;
    out_ready    = 1'b1;
    pushes = 0;
    k = 0;
    for (int c = 0; c < 600 && k < 257; c++) begin
      in_valid = (pushes < 257);
      in_data  = 32'(pushes);
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk($sformatf("t4b.data[%0d]", k), out_data, 32'(k));
        chk($sformatf("t4b.tlast[%0d]", k), 32'(out_tlast), 32'(k == 255));
        k++;
      end
      @(posedge clock); #1;
      if (acc) pushes++;
    end
    in_valid = 1'b0;
    chk("t4b.beats", 32'(k), 257);
    #1;
    chk("t4b.frame_count", 32'(frame_count), 4);

    do_reset("t5");
    run_tbl(t5, "t5");

    // Test 2: fill to 16 with output stalled, single pop, refill, then drain in order.
    do_reset("t2");
    frame_length = 9'd4;
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    nxt = 0;
    for (int c = 0; c < 20; c++) begin
      in_data = 32'h100 + 32'(nxt);
      in_dest = 8'(nxt);
      #1;
      acc = in_ready;
      @(posedge clock); #1;
      if (acc) nxt++;
    end
    chk("t2.accepted", 32'(nxt), 16);
    in_data = 32'h110;
    in_dest = 8'd16;
    #1;
    chk("t2.full_fill", 32'(fill_level), 16);
    chk("t2.full_ready", 32'(in_ready), 0);
    chk("t2.stall_valid", 32'(out_valid), 1);
    chk("t2.stall_data", out_data, 32'h100);
    chk("t2.stall_tlast", 32'(out_tlast), 0);
    out_ready = 1'b1;
    #1;
    chk("t2.pop_ready_still_low", 32'(in_ready), 0);
    @(posedge clock); #1;
    out_ready = 1'b0;
    #1;
    chk("t2.after_pop_fill", 32'(fill_level), 15);
    chk("t2.after_pop_ready", 32'(in_ready), 1);
    chk("t2.after_pop_head", out_data, 32'h101);
    @(posedge clock); #1;
    in_valid = 1'b0;
    #1;
    chk("t2.refill_fill", 32'(fill_level), 16);
    chk("t2.refill_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 16; c++) begin
      #1;
      if (out_valid) begin
        chk($sformatf("t2.data[%0d]", k), out_data, 32'h101 + 32'(k));
        chk($sformatf("t2.dest[%0d]", k), 32'(out_dest), 32'(k + 1));
        chk($sformatf("t2.tlast[%0d]", k), 32'(out_tlast), 32'(((k + 1) % 4) == 3));
        k++;
      end
      @(posedge clock); #1;
    end
    chk("t2.drained", 32'(k), 16);
    #1;
    chk("t2.frame_count", 32'(frame_count), 4);
    chk("t2.empty_fill", 32'(fill_level), 0);

    // Test 6: six words stored mid-frame, then reset.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h200 + 32'(i);
      in_dest  = 8'h00;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    #1;
    chk("t6.stored_fill", 32'(fill_level), 6);
    chk("t6.stored_valid", 32'(out_valid), 1);
    do_reset("t6");
    run_tbl(t6, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
